// File: rtl/key_hash_pkg.sv
// Shared definitions for the key-to-address hasher: mode encodings,
// fold geometry helper and a width-parametric left rotate.
package key_hash_pkg;

  typedef enum logic {
    HASH_MODE_XOR    = 1'b0,
    HASH_MODE_ROTXOR = 1'b1
  } hash_mode_e;

  localparam int unsigned ROT_MAX_W = 64;

  function automatic int unsigned chunk_count(input int unsigned key_w,
                                              input int unsigned key_lsb,
                                              input int unsigned addr_w);
    return (key_w - key_lsb + addr_w - 1) / addr_w;
  endfunction

  // Rotates the low `width` bits of value left by amount; bits above width are zero.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] value,
                                                input int unsigned amount,
                                                input int unsigned width);
    logic [ROT_MAX_W-1:0] mask;
    logic [ROT_MAX_W-1:0] v;
    logic [ROT_MAX_W-1:0] r;
    mask = (width >= ROT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    v = value & mask;
    if (amount == 0) r = v;
    else r = ((v << amount) | (v >> (width - amount))) & mask;
    return r;
  endfunction

endpackage

// File: rtl/key_hash_addr_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; the head
// entry is presented on rd_data whenever count is non-zero.
module hash_out_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  // A write at full is allowed when the head is leaving in the same cycle.
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && ((count != (AW+1)'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/key_hash_addr.sv
// Folds a wide key into a table address (plain or rotate XOR per request),
// with a registered input stage and an output FIFO for table-side stalls.
module key_hash_addr
  import key_hash_pkg::*;
#(
  parameter int unsigned KEY_W     = 128,
  parameter int unsigned KEY_LSB   = 16,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy,
  output logic [15:0]       hash_cnt
);

  localparam int unsigned NCHUNK = chunk_count(KEY_W, KEY_LSB, ADDR_W);
  localparam int unsigned PW     = NCHUNK * ADDR_W;
  localparam int unsigned CW     = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned FIFO_W = ADDR_W + TAG_W;

  // Chunks above the key field are zero-padded by the width cast.
  function automatic logic [ADDR_W-1:0] fold(input logic [KEY_W-1:0] key,
                                             input logic mode);
    logic [PW-1:0]     field;
    logic [ADDR_W-1:0] chunk;
    logic [ADDR_W-1:0] acc;
    field = PW'(key >> KEY_LSB);
    acc = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      chunk = field[i*ADDR_W +: ADDR_W];
      if (mode == HASH_MODE_ROTXOR)
        chunk = ADDR_W'(rotl(ROT_MAX_W'(chunk), i % ADDR_W, ADDR_W));
      acc ^= chunk;
    end
    return acc;
  endfunction

  logic              run;
  logic              accept;
  logic              vld_p1;
  logic [KEY_W-1:0]  key_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic              mode_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [FIFO_W-1:0] fifo_data;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;

  assign accept    = in_valid && in_ready;
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1};
  assign in_ready  = run && (occupancy < (CW+1)'(OUT_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      run    <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      run    <= 1'b1;
      vld_p1 <= accept;
    end
  end

  // Stage S1: captured request
  always_ff @(posedge clk) begin
    if (accept) begin
      key_p1  <= in_key;
      tag_p1  <= in_tag;
      mode_p1 <= in_mode;
    end
  end

  assign addr_p1 = fold(key_p1, mode_p1);

  // Stage S2: folded address and tag land in the output FIFO
  hash_out_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (vld_p1),
    .wr_data({addr_p1, tag_p1}),
    .rd_en  (out_ready),
    .rd_data(fifo_data),
    .count  (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_addr  = out_valid ? fifo_data[FIFO_W-1:TAG_W] : '0;
  assign out_tag   = out_valid ? fifo_data[TAG_W-1:0] : '0;
  assign busy      = vld_p1 || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (reset) hash_cnt <= '0;
    else if (out_valid && out_ready) hash_cnt <= hash_cnt + 16'd1;
  end

endmodule
